uart_rx_deserializador: RTL and testbench
=========================================

# uart_rx_deserializador

Receive-side UART stage for the peripheral interface. Samples the asynchronous serial line `rx` and rebuilds 8N1 frames, LSB first, into bytes. Holds each byte in a one-entry buffer with a valid/read handshake, and this buffer drives the byte to the PC-data register and display logic. Framing errors and overruns are flagged.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 868: clock cycles per bit (100 MHz / 115200). Must be even and ≥ 4.

Ports:
- `clk_i`  in  1  system clock. All logic lives in this single clock domain.
- `reset_n_pi`  in  1  asynchronous, active-low reset.
- `rx_pi`  in  1  serial line. Asynchronous to `clk_i`; idles high.
- `leer_pi`  in  1  consumer has read `dato_po`. Sampled on `clk_i`.
- `dato_po`  out  8  last correctly received byte.
- `dato_valido_po`  out  1  `dato_po` holds an unread byte (level).
- `error_trama_po`  out  1  one-cycle pulse: stop bit sampled low.
- `sobrecarga_po`  out  1  sticky: an unread byte was overwritten.
- `ocupado_po`  out  1  a frame is being received (state ≠ IDLE).

## Operation
- **Synchronizer.** `rx_pi` passes through 2 flops (`rx_s`). Both flops reset to 1. `rx_s` is the only copy of the line used internally.
- **Counters.** Bit counter `cnt` is $clog2(CLKS_PER_BIT) bits wide. Bit index `idx` is 3 bits. Shift register `sh` is 8 bits.
- **FSM states.** IDLE, START, DATA, STOP.
- **IDLE.** If `rx_s`==0, go to START and set `cnt`=0.
- **START.** Increment `cnt`. When `cnt`==CLKS_PER_BIT/2−1:
  - if `rx_s`==0, go to DATA with `cnt`=0 and `idx`=0;
  - otherwise the start bit was a glitch: go to IDLE.
- **DATA.** Increment `cnt`. When `cnt`==CLKS_PER_BIT−1:
  - set `sh` = {`rx_s`, `sh`[7:1]} (LSB first) and `cnt`=0;
  - if `idx`==7, go to STOP; otherwise `idx`++.
- **STOP.** Increment `cnt`. When `cnt`==CLKS_PER_BIT−1, always return to IDLE, then:
  - if `rx_s`==1, load `dato_po`←`sh` and set `dato_valido_po`=1;
  - if `rx_s`==0, pulse `error_trama_po` for one cycle and leave `dato_po`/`dato_valido_po` untouched.
- **Sample points.** Every sample is taken at mid-bit. The FSM re-arms half a bit before the nominal end of the stop bit.
- **Handshake.**
  - `leer_pi`=1 while `dato_valido_po`=1 clears `dato_valido_po` and `sobrecarga_po` at the next edge.
  - `leer_pi` while `dato_valido_po`=0 is ignored.
- **Simultaneous load and read.** A byte completing on the same edge as `leer_pi`: the new byte loads, `dato_valido_po` stays 1, and `sobrecarga_po` is not set.
- **Overrun.** A byte completing while `dato_valido_po`=1 and `leer_pi`=0 overwrites `dato_po` and sets `sobrecarga_po`.
- **Set wins over clear.** If an overrun-set and a clear coincide, the set wins. This case cannot occur given the rule above, but the RTL must encode the priority.
- **Continuous line low.** With `rx_s` stuck at 0, the block repeats frames with a framing error every 9.5 bit-times. It never loads data.

## Timing
- **Reset values.** On `reset_n_pi`=0 the following take effect immediately (asynchronously):
  - `dato_po`=8'h00, `dato_valido_po`=0, `error_trama_po`=0, `sobrecarga_po`=0, `ocupado_po`=0;
  - FSM=IDLE, `cnt`=0, `idx`=0, `sh`=0, synchronizer flops=1.
- **Reset mid-frame.** Abandons the frame and discards the partial byte. After release the block waits for a fresh falling edge.
- **Input latency.** `rx_pi` reaches `rx_s` 2 cycles later.
- **Busy.** `ocupado_po` rises 3 cycles after `rx_pi` falls.
- **Byte latency.** `dato_valido_po` (or `error_trama_po`) asserts 3 + CLKS_PER_BIT/2 + 9·CLKS_PER_BIT cycles after the `rx_pi` start edge. That is 155 cycles at CLKS_PER_BIT=16; the bench allows ±1.
- **Outputs.** All outputs are registered. There is no combinational path from `rx_pi` or `leer_pi` to any output.
- **Throughput.** Back-to-back frames with a 1-bit stop are accepted without loss, provided `leer_pi` arrives within one frame time.

## Test plan
Bench uses CLKS_PER_BIT=16.
1. **Reset.** Hold `reset_n_pi`=0 with `rx_pi` toggling → all outputs 0 and `ocupado_po` never rises. Release → block stays idle while `rx_pi`=1.
2. **Single frame.** Send 0xA5 (8N1) → `dato_po`=0xA5 and `dato_valido_po`=1 at 155±1 cycles after the start edge. Pulse `leer_pi` → valid=0 the next cycle and `dato_po` holds 0xA5.
3. **Glitch, then frame.** Low pulse on `rx_pi` of 4 cycles → FSM returns to IDLE with no outputs. Then send 0x00 and 0xFF back-to-back with `leer_pi` after each → two clean bytes, no errors.
4. **Framing error.** Send 0x3C with the stop bit driven low → `error_trama_po` is a 1-cycle pulse, and `dato_po`/`dato_valido_po` keep their previous values (0x00/0).
5. **Overrun.** Send 0x11 then 0x22 without `leer_pi` → `dato_po`=0x22, valid=1, `sobrecarga_po`=1. `leer_pi` clears both flags. A separate run drives `leer_pi` on the exact completion edge of a second byte → valid stays 1 and `sobrecarga_po` stays 0.
6. **Reset mid-frame.** Assert reset after data bit 3 of 0xC3 → outputs 0 at once. Release and send 0x5A → `dato_po`=0x5A with no leftover bits.

Source files
------------

// File: rtl/uart_rx_deserializador_if.sv
`timescale 1ns/1ps
// Signal bundle between the serial line / byte consumer and the UART receiver.
// slave: the receiver side. master: the line driver and byte consumer side.
interface uart_rx_deserializador_if;
  logic       rx_pi;
  logic       leer_pi;
  logic [7:0] dato_po;
  logic       dato_valido_po;
  logic       error_trama_po;
  logic       sobrecarga_po;
  logic       ocupado_po;

  modport slave (
    input  rx_pi,
    input  leer_pi,
    output dato_po,
    output dato_valido_po,
    output error_trama_po,
    output sobrecarga_po,
    output ocupado_po
  );

  modport master (
    output rx_pi,
    output leer_pi,
    input  dato_po,
    input  dato_valido_po,
    input  error_trama_po,
    input  sobrecarga_po,
    input  ocupado_po
  );
endinterface

// File: rtl/uart_rx_deserializador.sv
`timescale 1ns/1ps
// 8N1 UART receiver, LSB first. A two-flop synchronizer feeds a mid-bit
// sampling FSM; finished bytes land in a one-entry buffer with a
// valid/read handshake, framing-error pulse and sticky overrun flag.
module uart_rx_deserializador #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic                      clk_i,
  input  logic                      reset_n_pi,
  uart_rx_deserializador_if.slave   bus
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  logic          rx_meta_q, rx_meta_d;
  logic          rx_s_q, rx_s_d;
  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    sh_q, sh_d;
  logic [7:0]    dato_q, dato_d;
  logic          valido_q, valido_d;
  logic          err_q, err_d;
  logic          ovr_q, ovr_d;
  logic          busy_q, busy_d;
  logic          frame_ok;
  logic          frame_err;

  // Synchronizer inputs: rx_s_q is the only copy of the line used below.
  always_comb begin
    rx_meta_d = bus.rx_pi;
    rx_s_d    = rx_meta_q;
  end

  // Frame FSM: start-bit check at half a bit, then one sample per bit period
  // so every data and stop sample lands mid-bit.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    sh_d      = sh_q;
    frame_ok  = 1'b0;
    frame_err = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!rx_s_q) begin
          state_d = ST_START;
          cnt_d   = '0;
        end
      end
      ST_START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d = '0;
          if (!rx_s_q) begin
            state_d = ST_DATA;
            idx_d   = 3'd0;
          end else begin
            // Line went back high before mid start bit: treat as a glitch.
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_DATA: begin
        if (cnt_q == FULL_M1) begin
          sh_d  = {rx_s_q, sh_q[7:1]};
          cnt_d = '0;
          if (idx_q == 3'd7) begin
            state_d = ST_STOP;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_STOP: begin
        // Re-arm at mid stop bit so a back-to-back start edge is not missed.
        if (cnt_q == FULL_M1) begin
          state_d   = ST_IDLE;
          cnt_d     = '0;
          frame_ok  = rx_s_q;
          frame_err = !rx_s_q;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output buffer and handshake; a load is applied after the read-clear so
  // the overrun set always wins over a clear on the same edge.
  always_comb begin
    dato_d   = dato_q;
    valido_d = valido_q;
    ovr_d    = ovr_q;
    err_d    = frame_err;
    busy_d   = (state_d != ST_IDLE);
    if (bus.leer_pi && valido_q) begin
      valido_d = 1'b0;
      ovr_d    = 1'b0;
    end
    if (frame_ok) begin
      dato_d   = sh_q;
      valido_d = 1'b1;
      if (valido_q && !bus.leer_pi) begin
        ovr_d = 1'b1;
      end
    end
  end

  // State registers with asynchronous active-low reset; line flops idle high.
  always_ff @(posedge clk_i or negedge reset_n_pi) begin
    if (!reset_n_pi) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      idx_q     <= 3'd0;
      sh_q      <= 8'h00;
      dato_q    <= 8'h00;
      valido_q  <= 1'b0;
      err_q     <= 1'b0;
      ovr_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      rx_meta_q <= rx_meta_d;
      rx_s_q    <= rx_s_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      sh_q      <= sh_d;
      dato_q    <= dato_d;
      valido_q  <= valido_d;
      err_q     <= err_d;
      ovr_q     <= ovr_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.dato_po        = dato_q;
  assign bus.dato_valido_po = valido_q;
  assign bus.error_trama_po = err_q;
  assign bus.sobrecarga_po  = ovr_q;
  assign bus.ocupado_po     = busy_q;

endmodule

// File: tb/tb_uart_rx_deserializador.sv
`timescale 1ns/1ps
// Bench for uart_rx_deserializador at 16 clocks per bit. Frames are pushed to
// a scoreboard as they are driven; a negedge monitor pops and checks them.
module tb_uart_rx_deserializador;

  localparam int CPB = 16;
  localparam int LAT = 3 + CPB / 2 + 9 * CPB;
  localparam int FRAME = 10 * CPB;

  typedef struct {
    logic [7:0] data;
    bit         err;
    int         due;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  exp_t sb[$];

  logic       prev_valid = 1'b0;
  logic       prev_err = 1'b0;
  logic [7:0] prev_dato = 8'h00;

  uart_rx_deserializador_if bus();

  uart_rx_deserializador #(.CLKS_PER_BIT(CPB)) dut (
    .clk_i      (clk),
    .reset_n_pi (reset_n),
    .bus        (bus.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Transaction monitor: every framing-error pulse or newly loaded byte
  // consumes one scoreboard entry.
  always @(negedge clk) begin
    exp_t e;
    if (reset_n) begin
      if (bus.error_trama_po) begin
        n_tests++;
        if (prev_err) begin
          n_fail++;
          $display("FAIL err_pulse_width: error_trama_po high for 2+ cycles at cycle %0d, required 1 cycle", cyc);
        end
      end
      if (bus.error_trama_po || (bus.dato_valido_po && (!prev_valid || bus.dato_po !== prev_dato))) begin
        n_tests++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_output: cycle %0d dato=%02h err=%0b, required no transaction", cyc, bus.dato_po, bus.error_trama_po);
        end else begin
          e = sb.pop_front();
          if (bus.error_trama_po !== e.err || (!e.err && bus.dato_po !== e.data) ||
              cyc < e.due - 1 || cyc > e.due + 1) begin
            n_fail++;
            $display("FAIL rx_transaction: got dato=%02h err=%0b cycle=%0d, required dato=%02h err=%0b cycle=%0d+-1",
                     bus.dato_po, bus.error_trama_po, cyc, e.data, e.err, e.due);
          end else begin
            $display("[TB] rx dato=%02h err=%0b latency=%0d", bus.dato_po, bus.error_trama_po, cyc - (e.due - LAT));
          end
        end
      end
    end
    prev_valid = bus.dato_valido_po;
    prev_err   = bus.error_trama_po;
    prev_dato  = bus.dato_po;
  end

  task automatic wait_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drive one 8N1 frame; the scoreboard entry is pushed at the start edge.
  task automatic send_byte(input logic [7:0] data, input logic stop_bit);
    exp_t e;
    e.data = data;
    e.err  = !stop_bit;
    e.due  = cyc + LAT;
    sb.push_back(e);
    bus.rx_pi = 1'b0;
    wait_cycles(CPB);
    for (int i = 0; i < 8; i++) begin
      bus.rx_pi = data[i];
      wait_cycles(CPB);
    end
    bus.rx_pi = stop_bit;
    wait_cycles(CPB);
    bus.rx_pi = 1'b1;
  endtask

  task automatic apply_reset();
    reset_n     = 1'b0;
    bus.rx_pi   = 1'b1;
    bus.leer_pi = 1'b0;
    wait_cycles(3);
    reset_n = 1'b1;
    wait_cycles(3);
  endtask

  // Waits (bounded) for a valid byte, reads it and checks the clear.
  task automatic read_when_valid(input string name);
    int k;
    k = 0;
    while (!bus.dato_valido_po && k < 400) begin
      wait_cycles(1);
      k++;
    end
    n_tests++;
    if (!bus.dato_valido_po) begin
      n_fail++;
      $display("FAIL %s_wait_valid: dato_valido_po=0 after 400 cycles, required 1", name);
    end else begin
      bus.leer_pi = 1'b1;
      wait_cycles(1);
      bus.leer_pi = 1'b0;
      n_tests++;
      if (bus.dato_valido_po !== 1'b0) begin
        n_fail++;
        $display("FAIL %s_read_clear: dato_valido_po=%0b, required 0", name, bus.dato_valido_po);
      end
    end
  endtask

  task automatic test_reset();
    bus.rx_pi   = 1'b1;
    bus.leer_pi = 1'b0;
    reset_n     = 1'b0;
    for (int i = 0; i < 20; i++) begin
      bus.rx_pi = i[0];
      wait_cycles(1);
      n_tests++;
      if ({bus.dato_po, bus.dato_valido_po, bus.error_trama_po, bus.sobrecarga_po, bus.ocupado_po} !== 12'h000) begin
        n_fail++;
        $display("FAIL reset_outputs: dato=%02h v=%0b e=%0b o=%0b busy=%0b, required all 0",
                 bus.dato_po, bus.dato_valido_po, bus.error_trama_po, bus.sobrecarga_po, bus.ocupado_po);
      end
    end
    bus.rx_pi = 1'b1;
    wait_cycles(1);
    reset_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      wait_cycles(1);
      n_tests++;
      if (bus.ocupado_po !== 1'b0 || bus.dato_valido_po !== 1'b0) begin
        n_fail++;
        $display("FAIL idle_after_reset: busy=%0b valid=%0b, required 0/0", bus.ocupado_po, bus.dato_valido_po);
      end
    end
    $display("[TB] reset test done");
  endtask

  task automatic test_single_frame();
    send_byte(8'hA5, 1'b1);
    n_tests++;
    if (bus.dato_po !== 8'hA5 || bus.dato_valido_po !== 1'b1) begin
      n_fail++;
      $display("FAIL single_frame: dato=%02h valid=%0b, required A5/1", bus.dato_po, bus.dato_valido_po);
    end
    bus.leer_pi = 1'b1;
    wait_cycles(1);
    bus.leer_pi = 1'b0;
    n_tests++;
    if (bus.dato_valido_po !== 1'b0 || bus.dato_po !== 8'hA5) begin
      n_fail++;
      $display("FAIL single_read: dato=%02h valid=%0b, required A5/0", bus.dato_po, bus.dato_valido_po);
    end
    $display("[TB] single frame test done");
  endtask

  task automatic test_glitch_back_to_back();
    bus.rx_pi = 1'b0;
    wait_cycles(2);
    n_tests++;
    if (bus.ocupado_po !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_early: ocupado_po=%0b two cycles after fall, required 0", bus.ocupado_po);
    end
    wait_cycles(1);
    n_tests++;
    if (bus.ocupado_po !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_rise: ocupado_po=%0b three cycles after fall, required 1", bus.ocupado_po);
    end
    wait_cycles(1);
    bus.rx_pi = 1'b1;
    wait_cycles(8);
    n_tests++;
    if (bus.ocupado_po !== 1'b0 || bus.dato_valido_po !== 1'b0 || bus.error_trama_po !== 1'b0) begin
      n_fail++;
      $display("FAIL glitch_reject: busy=%0b valid=%0b err=%0b, required 0/0/0",
               bus.ocupado_po, bus.dato_valido_po, bus.error_trama_po);
    end
    wait_cycles(10);
    fork
      begin
        send_byte(8'h00, 1'b1);
        send_byte(8'hFF, 1'b1);
      end
      begin
        read_when_valid("b2b_first");
        read_when_valid("b2b_second");
      end
    join
    n_tests++;
    if (bus.dato_po !== 8'hFF || bus.dato_valido_po !== 1'b0 || bus.sobrecarga_po !== 1'b0) begin
      n_fail++;
      $display("FAIL back_to_back: dato=%02h valid=%0b ovr=%0b, required FF/0/0",
               bus.dato_po, bus.dato_valido_po, bus.sobrecarga_po);
    end
    $display("[TB] glitch and back-to-back test done");
  endtask

  task automatic test_framing_error();
    exp_t e;
    int   n;
    apply_reset();
    send_byte(8'h3C, 1'b0);
    wait_cycles(20);
    n_tests++;
    if (bus.dato_po !== 8'h00 || bus.dato_valido_po !== 1'b0 || bus.error_trama_po !== 1'b0) begin
      n_fail++;
      $display("FAIL framing_keep: dato=%02h valid=%0b err=%0b, required 00/0/0",
               bus.dato_po, bus.dato_valido_po, bus.error_trama_po);
    end
    // Line held low: a framing error every 9.5 bit times, never a byte.
    n = cyc;
    e.data = 8'h00;
    e.err  = 1'b1;
    e.due  = n + LAT;
    sb.push_back(e);
    e.due  = n + LAT + (19 * CPB) / 2;
    sb.push_back(e);
    bus.rx_pi = 1'b0;
    wait_cycles(310);
    bus.rx_pi = 1'b1;
    wait_cycles(30);
    n_tests++;
    if (bus.dato_valido_po !== 1'b0 || bus.dato_po !== 8'h00 || bus.ocupado_po !== 1'b0 || sb.size() != 0) begin
      n_fail++;
      $display("FAIL line_low: valid=%0b dato=%02h busy=%0b pending=%0d, required 0/00/0/0",
               bus.dato_valido_po, bus.dato_po, bus.ocupado_po, sb.size());
    end
    $display("[TB] framing error test done");
  endtask

  task automatic test_overrun();
    apply_reset();
    send_byte(8'h11, 1'b1);
    n_tests++;
    if (bus.sobrecarga_po !== 1'b0) begin
      n_fail++;
      $display("FAIL overrun_early: sobrecarga_po=%0b after first byte, required 0", bus.sobrecarga_po);
    end
    send_byte(8'h22, 1'b1);
    n_tests++;
    if (bus.dato_po !== 8'h22 || bus.dato_valido_po !== 1'b1 || bus.sobrecarga_po !== 1'b1) begin
      n_fail++;
      $display("FAIL overrun_set: dato=%02h valid=%0b ovr=%0b, required 22/1/1",
               bus.dato_po, bus.dato_valido_po, bus.sobrecarga_po);
    end
    bus.leer_pi = 1'b1;
    wait_cycles(1);
    bus.leer_pi = 1'b0;
    n_tests++;
    if (bus.dato_valido_po !== 1'b0 || bus.sobrecarga_po !== 1'b0) begin
      n_fail++;
      $display("FAIL overrun_clear: valid=%0b ovr=%0b, required 0/0", bus.dato_valido_po, bus.sobrecarga_po);
    end
    $display("[TB] overrun test done");
  endtask

  task automatic test_read_on_load();
    apply_reset();
    fork
      begin
        send_byte(8'h33, 1'b1);
        send_byte(8'h44, 1'b1);
      end
      begin
        // Read lands exactly on the completion edge of the second byte.
        wait_cycles(FRAME + LAT - 1);
        bus.leer_pi = 1'b1;
        wait_cycles(1);
        bus.leer_pi = 1'b0;
      end
    join
    n_tests++;
    if (bus.dato_po !== 8'h44 || bus.dato_valido_po !== 1'b1 || bus.sobrecarga_po !== 1'b0) begin
      n_fail++;
      $display("FAIL read_on_load: dato=%02h valid=%0b ovr=%0b, required 44/1/0",
               bus.dato_po, bus.dato_valido_po, bus.sobrecarga_po);
    end
    $display("[TB] read-on-load test done");
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] b;
    b = 8'hC3;
    bus.rx_pi = 1'b0;
    wait_cycles(CPB);
    for (int i = 0; i < 4; i++) begin
      bus.rx_pi = b[i];
      wait_cycles(CPB);
    end
    reset_n = 1'b0;
    #1;
    n_tests++;
    if ({bus.dato_po, bus.dato_valido_po, bus.error_trama_po, bus.sobrecarga_po, bus.ocupado_po} !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_async: dato=%02h v=%0b e=%0b o=%0b busy=%0b, required all 0 before next edge",
               bus.dato_po, bus.dato_valido_po, bus.error_trama_po, bus.sobrecarga_po, bus.ocupado_po);
    end
    bus.rx_pi = 1'b1;
    wait_cycles(3);
    reset_n = 1'b1;
    wait_cycles(5);
    send_byte(8'h5A, 1'b1);
    n_tests++;
    if (bus.dato_po !== 8'h5A || bus.dato_valido_po !== 1'b1 || bus.sobrecarga_po !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_frame: dato=%02h valid=%0b ovr=%0b, required 5A/1/0",
               bus.dato_po, bus.dato_valido_po, bus.sobrecarga_po);
    end
    $display("[TB] reset mid-frame test done");
  endtask

  initial begin
    bus.rx_pi   = 1'b1;
    bus.leer_pi = 1'b0;
    test_reset();
    test_single_frame();
    test_glitch_back_to_back();
    test_framing_error();
    test_overrun();
    test_read_on_load();
    test_reset_mid_frame();
    wait_cycles(10);
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d transactions outstanding, required 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
